// File: rtl/ofdm_rx_cp_remover.sv
// OFDM receive CP remover: drops the training preamble after sync, then strips
// the cyclic prefix of each symbol and emits indexed FFT_LEN-sample blocks.
// Ports: clk, rst (sync, active-high); din_re/din_im/din_vld, sync_pulse,
//   sym_num in; dout_re/dout_im/dout_vld/dout_index, sym_start, sym_cnt,
//   frame_done, busy, err out.
// Optional macro RX_GAP_TIMEOUT_EN: abort the frame after GAP_MAX idle cycles.
module ofdm_rx_cp_remover #(
  parameter int DW        = 8,
  parameter int CP_LEN    = 16,
  parameter int FFT_LEN   = 64,
  parameter int TRAIN_LEN = 320,
  parameter int SYM_W     = 12,
  parameter int GAP_MAX   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DW-1:0]       din_re,
  input  logic signed [DW-1:0]       din_im,
  input  logic                       din_vld,
  input  logic                       sync_pulse,
  input  logic [SYM_W-1:0]           sym_num,
  output logic signed [DW-1:0]       dout_re,
  output logic signed [DW-1:0]       dout_im,
  output logic                       dout_vld,
  output logic [$clog2(FFT_LEN)-1:0] dout_index,
  output logic                       sym_start,
  output logic [SYM_W-1:0]           sym_cnt,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       err
);

  localparam int IW = $clog2(FFT_LEN);
  localparam int L1 = (TRAIN_LEN > CP_LEN) ? TRAIN_LEN : CP_LEN;
  localparam int LM = (L1 > FFT_LEN) ? L1 : FFT_LEN;
  localparam int CW = $clog2(LM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAIN,
    S_CP,
    S_DATA,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     samp, samp_n;
  logic [SYM_W-1:0]  sidx, sidx_n;
  logic [SYM_W-1:0]  lat, lat_n;
  logic [DW-1:0]     re_n, im_n;
  logic              vld_n, ss_n, fd_n, busy_n, err_n;
  logic [IW-1:0]     idx_n;
  logic [SYM_W-1:0]  cnt_n;
  logic              sync_ok, start;

`ifdef RX_GAP_TIMEOUT_EN
  localparam int GW = $clog2(GAP_MAX + 1);
  logic [GW-1:0]     gap, gap_n;
`else
  // Parameter kept so both builds share one parameter list.
  if (GAP_MAX < 0) begin : g_no_gap
  end
`endif

  assign sync_ok = din_vld & sync_pulse;

  always_comb begin
    state_n = state;
    samp_n  = samp;
    sidx_n  = sidx;
    lat_n   = lat;
    re_n    = dout_re;
    im_n    = dout_im;
    vld_n   = 1'b0;
    idx_n   = dout_index;
    ss_n    = 1'b0;
    cnt_n   = sym_cnt;
    // Status flags lag the state by one cycle, like the data path.
    fd_n    = (state == S_DONE);
    busy_n  = (state != S_IDLE);
    err_n   = 1'b0;
    start   = 1'b0;
`ifdef RX_GAP_TIMEOUT_EN
    gap_n   = gap;
`endif

    unique case (state)
      S_IDLE: begin
        if (sync_ok) start = 1'b1;
      end
      S_TRAIN: begin
        if (sync_ok) begin
          start = 1'b1;
          err_n = 1'b1;
        end else if (din_vld) begin
          if (samp == CW'(TRAIN_LEN - 1)) begin
            state_n = S_CP;
            samp_n  = '0;
          end else begin
            samp_n = samp + CW'(1);
          end
        end
      end
      S_CP: begin
        if (sync_ok) begin
          start = 1'b1;
          err_n = 1'b1;
        end else if (din_vld) begin
          if (samp == CW'(CP_LEN - 1)) begin
            state_n = S_DATA;
            samp_n  = '0;
          end else begin
            samp_n = samp + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (sync_ok) begin
          start = 1'b1;
          err_n = 1'b1;
        end else if (din_vld) begin
          re_n  = din_re;
          im_n  = din_im;
          vld_n = 1'b1;
          idx_n = samp[IW-1:0];
          ss_n  = (samp == '0);
          cnt_n = sidx;
          if (samp == CW'(FFT_LEN - 1)) begin
            samp_n = '0;
            if (sidx == lat - SYM_W'(1)) begin
              state_n = S_DONE;
            end else begin
              sidx_n  = sidx + SYM_W'(1);
              state_n = S_CP;
            end
          end else begin
            samp_n = samp + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        if (sync_ok) start = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // The sync sample is preamble sample 0, so counting resumes at 1.
    if (start) begin
      state_n = S_TRAIN;
      samp_n  = CW'(1);
      sidx_n  = '0;
      cnt_n   = '0;
      lat_n   = (sym_num == '0) ? SYM_W'(1) : sym_num;
    end

`ifdef RX_GAP_TIMEOUT_EN
    if (din_vld || state == S_IDLE || state == S_DONE) begin
      gap_n = '0;
    end else if (gap == GW'(GAP_MAX - 1)) begin
      gap_n   = '0;
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else begin
      gap_n = gap + GW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      samp       <= '0;
      sidx       <= '0;
      lat        <= '0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_vld   <= 1'b0;
      dout_index <= '0;
      sym_start  <= 1'b0;
      sym_cnt    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
`ifdef RX_GAP_TIMEOUT_EN
      gap        <= '0;
`endif
    end else begin
      state      <= state_n;
      samp       <= samp_n;
      sidx       <= sidx_n;
      lat        <= lat_n;
      dout_re    <= re_n;
      dout_im    <= im_n;
      dout_vld   <= vld_n;
      dout_index <= idx_n;
      sym_start  <= ss_n;
      sym_cnt    <= cnt_n;
      frame_done <= fd_n;
      busy       <= busy_n;
      err        <= err_n;
`ifdef RX_GAP_TIMEOUT_EN
      gap        <= gap_n;
`endif
    end
  end

endmodule

// File: tb/tb_ofdm_rx_cp_remover.sv
// Directed bench for ofdm_rx_cp_remover: ramp frames, stalls, sym_num=0,
// resync, gap handling and mid-frame reset, checked by immediate assertions.
module tb_ofdm_rx_cp_remover;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din_re, din_im;
  logic        din_vld, sync_pulse;
  logic [11:0] sym_num;
  logic [7:0]  dout_re, dout_im;
  logic        dout_vld;
  logic [5:0]  dout_index;
  logic        sym_start;
  logic [11:0] sym_cnt;
  logic        frame_done, busy, err;

  always #5 clk = ~clk;

  ofdm_rx_cp_remover dut (
    .clk(clk), .rst(rst),
    .din_re(din_re), .din_im(din_im),
    .din_vld(din_vld), .sync_pulse(sync_pulse),
    .sym_num(sym_num),
    .dout_re(dout_re), .dout_im(dout_im),
    .dout_vld(dout_vld), .dout_index(dout_index),
    .sym_start(sym_start), .sym_cnt(sym_cnt),
    .frame_done(frame_done), .busy(busy), .err(err)
  );

  int total = 0;
  int bad = 0;

  // Reference model state: frame activity and position since sync.
  bit act = 0;
  int pos = 0;
  int nl = 1;
  int gap = 0;
  int g = 0;
  int k = 0;
  int done_at = -5;
  int outs, starts, fds, errs;
  int first_re;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    outs = 0; starts = 0; fds = 0; errs = 0; first_re = -1;
  endtask

  task automatic tick(input bit v, input bit s, input int sn);
    logic [7:0] re, im;
    bit ev, ee, es;
    int q, sy, r;
    re = g[7:0];
    im = 8'(g * 3 + 1);
    din_re = re; din_im = im;
    din_vld = v; sync_pulse = s; sym_num = 12'(sn);
    ev = 0; ee = 0; es = 0; sy = 0; r = 0;
    if (v) begin
      if (s) begin
        ee = act; act = 1; pos = 0;
        nl = (sn == 0) ? 1 : sn;
      end else if (act) begin
        pos++;
      end
      if (act && pos >= 336) begin
        q = pos - 336; sy = q / 80; r = q % 80;
        if (r < 64 && sy < nl) begin
          ev = 1; es = (r == 0);
          if (sy == nl - 1 && r == 63) begin
            act = 0; done_at = k + 1;
          end
        end
      end
      gap = 0;
      g++;
    end else if (act) begin
`ifdef RX_GAP_TIMEOUT_EN
      gap++;
      if (gap == 255) begin
        ee = 1; act = 0; gap = 0;
      end
`endif
    end
    @(posedge clk);
    #1;
    chk("dout_vld", dout_vld, ev);
    chk("sym_start", sym_start, es);
    if (ev) begin
      chk("dout_re", dout_re, re);
      chk("dout_im", dout_im, im);
      chk("dout_index", dout_index, r);
      chk("sym_cnt", sym_cnt, sy);
    end
    chk("frame_done", frame_done, k == done_at);
    chk("err", err, ee);
    if (dout_vld) begin
      if (outs == 0) first_re = dout_re;
      outs++;
    end
    if (sym_start) starts++;
    if (frame_done) fds++;
    if (err) errs++;
    k++;
  endtask

  task automatic do_reset();
    rst = 1; din_vld = 0; sync_pulse = 0;
    @(posedge clk);
    #1;
    rst = 0;
    act = 0; gap = 0; done_at = -5; k++;
    chk("rst_vld", dout_vld, 0);
    chk("rst_re", dout_re, 0);
    chk("rst_im", dout_im, 0);
    chk("rst_idx", dout_index, 0);
    chk("rst_ss", sym_start, 0);
    chk("rst_cnt", sym_cnt, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
  endtask

  initial begin
    rst = 1; din_re = 0; din_im = 0; din_vld = 0;
    sync_pulse = 0; sym_num = 0;
    @(posedge clk);
    do_reset();

    // Two-symbol frame, continuous valid, ramp = sample number.
    clr(); g = 0;
    for (int i = 0; i < 500; i++) tick(1, i == 0, 2);
    chk("f1_first_re", first_re, 80);
    chk("f1_outs", outs, 128);
    chk("f1_starts", starts, 2);
    chk("f1_fd", fds, 1);
    chk("f1_cnt_hold", sym_cnt, 1);
    chk("f1_busy", busy, 0);

    // Same frame with din_vld toggling every cycle.
    clr(); g = 0;
    for (int i = 0; i < 1100; i++) tick(i % 2 == 0, i == 0, 2);
    chk("f2_first_re", first_re, 80);
    chk("f2_outs", outs, 128);
    chk("f2_starts", starts, 2);
    chk("f2_fd", fds, 1);

    // sym_num = 0 behaves as one symbol.
    clr();
    for (int i = 0; i < 420; i++) tick(1, i == 0, 0);
    chk("f3_outs", outs, 64);
    chk("f3_fd", fds, 1);
    chk("f3_cnt", sym_cnt, 0);

    // Resync at data index 20 of symbol 0.
    clr();
    for (int i = 0; i < 356; i++) tick(1, i == 0, 1);
    chk("f4_part", outs, 20);
    chk("f4_busy", busy, 1);
    tick(1, 1, 1);
    for (int i = 0; i < 420; i++) tick(1, 0, 1);
    chk("f4_outs", outs, 84);
    chk("f4_starts", starts, 2);
    chk("f4_err", errs, 1);
    chk("f4_fd", fds, 1);

    // Long din_vld gap inside the cyclic prefix.
    clr();
    for (int i = 0; i < 330; i++) tick(1, i == 0, 1);
    for (int i = 0; i < 300; i++) tick(0, 0, 1);
`ifdef RX_GAP_TIMEOUT_EN
    chk("f5_busy", busy, 0);
    chk("f5_err", errs, 1);
`else
    chk("f5_busy", busy, 1);
    chk("f5_err", errs, 0);
`endif
    for (int i = 0; i < 120; i++) tick(1, 0, 1);
`ifdef RX_GAP_TIMEOUT_EN
    chk("f5_outs", outs, 0);
    chk("f5_fd", fds, 0);
`else
    chk("f5_outs", outs, 64);
    chk("f5_fd", fds, 1);
`endif

    // Reset in the middle of a data symbol.
    clr();
    for (int i = 0; i < 350; i++) tick(1, i == 0, 1);
    chk("f6_pre", outs, 14);
    do_reset();
    clr();
    for (int i = 0; i < 100; i++) tick(1, 0, 1);
    chk("f6_outs", outs, 0);
    chk("f6_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
